sdf_fft_ctrl: RTL
=================

# sdf_fft_ctrl

Central sequencer for the 128-point single-delay-feedback (SDF) FFT pipeline. It takes the input sample handshake and produces, per stage, the butterfly/feedback select and a one-cycle start pulse for that stage's twiddle address generator. Frames flow back-to-back through the stages. The block also emits output valid and start-of-frame markers and flags input protocol violations. It sits beside the stage datapaths and drives only control signals; no sample data passes through it.

## Interface
- NFFT, 128, FFT length; power of two, ≥ 8; L = log2(NFFT) stages
- BF_LAT, 1, register latency of one stage's butterfly plus twiddle multiply; range 0 ≤ BF_LAT < NFFT/2
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input sample present this cycle
- in_sof  input  1  first sample of a frame; qualified by in_valid
- bf_sel  output  L  bit s-1 = 1: stage s in butterfly phase; 0: stage s in fill/feedback phase
- tw_active  output  L  bit s-1: one-cycle start pulse to stage s twiddle address generator
- out_valid  output  1  bit-reversed FFT output sample present
- out_sof  output  1  first output sample of a frame
- busy  output  1  any frame in flight
- err_protocol  output  1  sticky protocol error; cleared only by rst

## Operation
- All outputs are registered. On reset, every output is 0, all counters are 0, and all pending stage tokens are cleared. Reset asserted mid-frame discards all frames in flight; outputs are 0 in the cycle after rst is sampled.
- Input framing: a frame is accepted at cycle c0, where in_valid=1 and in_sof=1 with the input counter idle. in_valid must then stay 1 for exactly NFFT consecutive cycles (c0 .. c0+NFFT-1). A new in_sof is legal at c0+NFFT, which gives back-to-back streaming.
- in_sof while the input counter is in frame (index 1..NFFT-1): set err_protocol. The in_sof is ignored and the current frame continues.
- in_valid=0 mid-frame: set err_protocol and flush. All stage counters and tokens clear, bf_sel, out_valid and busy go to 0 the next cycle, and the block waits for a new in_sof.
- in_valid without in_sof while idle: ignored, no error.
- Stage start times:
  - T_1 = c0 + 2 (one input register plus alignment cycle).
  - T_{s+1} = T_s + D_s + BF_LAT, where D_s = NFFT >> s.
- Each stage has one start-token down-counter. The BF_LAT bound guarantees at most one pending token per stage, including for back-to-back frames.
- Stage s local index k = cycle − T_s, for 0 ≤ k ≤ NFFT-1. The local counter wraps from NFFT-1 to 0 seamlessly when the next frame's token lands on the same cycle.
- bf_sel[s-1] = k[L−s] while stage s is active, otherwise 0. For stage L this is k[0].
- tw_active[s-1] = 1 in cycle T_s − 1 only. This makes the generator's index 0 coincide with k = 0. The pulse is issued once per frame, including for back-to-back frames.
- Output: out_valid = 1 for cycles T_{L+1} .. T_{L+1}+NFFT-1, and out_sof = 1 at T_{L+1}.
- busy = 1 from c0+1 until the last out_valid cycle inclusive.

## Timing
- Total latency, in_sof to out_sof: 2 + (NFFT−1) + L·BF_LAT cycles. For the defaults this is 2 + 127 + 7 = 136.
- Back-to-back frames: out_valid stays continuously high, with out_sof every NFFT cycles.
- Simultaneous events:
  - rst has priority over everything.
  - A flush takes priority over the next in_sof sampled in the same cycle; that in_sof is dropped.
  - err_protocol, once set, does not stall operation.
- Width rules:
  - Stage and input counters are log2(NFFT) bits and wrap modulo NFFT.
  - Token delay counters are wide enough for D_1 + BF_LAT.

## Test plan
- NFFT=8, BF_LAT=1, in_sof at c0=0 with 8 valid cycles:
  - tw_active[0]@1, [1]@6, [2]@9.
  - bf_sel[0]=1 for cycles 6–9.
  - bf_sel[1]=1 for cycles 9,10,13,14.
  - bf_sel[2]=1 for cycles 11,13,15,17.
  - out_sof@12, out_valid 12–19, busy 1–19.
- Same config, frames at c0=0 and c0=8: out_valid continuous 12–27, out_sof@12 and @20, tw_active[2] pulses @9 and @17.
- Defaults (128, 1): single frame → out_sof exactly 136 cycles after in_sof; bf_sel[6] toggles every cycle.
- in_valid dropped at frame index 3:
  - err_protocol=1 from the next cycle onward.
  - bf_sel, out_valid and busy go to 0.
  - A later clean frame completes normally with err_protocol still 1.
- Extra in_sof at index 5: err_protocol=1; frame output timing unchanged.
- rst pulsed at the cycle of out_sof: all outputs 0 the next cycle; no further out_valid; err_protocol cleared.

Source files
------------

// File: rtl/sdf_fft_ctrl.sv
// Central control sequencer for an NFFT-point SDF FFT pipeline: per-stage
// butterfly/feedback select, twiddle start pulses, output framing, protocol check.
module sdf_fft_ctrl #(
  parameter int NFFT   = 128,
  parameter int BF_LAT = 1,
  localparam int L     = $clog2(NFFT),
  localparam int TW    = $clog2(NFFT / 2 + BF_LAT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic [L-1:0] bf_sel,
  output logic [L-1:0] tw_active,
  output logic         out_valid,
  output logic         out_sof,
  output logic         busy,
  output logic         err_protocol
);

  // Slot j (0..L-1) is stage j+1; slot L is the output framing window.
  logic          in_act, n_in_act;
  logic [L-1:0]  in_cnt, n_in_cnt;
  logic          accept, flush, sof_err;
  logic [L:0]    tok_vld, n_tok_vld, expire, load;
  logic [L:0]    st_act, n_st_act;
  logic [TW-1:0] tok_cnt   [0:L];
  logic [TW-1:0] n_tok_cnt [0:L];
  logic [L-1:0]  st_k      [0:L];
  logic [L-1:0]  n_st_k    [0:L];
  logic [L-1:0]  n_bf_sel, n_tw_active;

  // A token loaded with delay d expires d+1 cycles later, the cycle before
  // its stage starts, which is exactly when the twiddle pulse is due.
  function automatic logic [TW-1:0] tok_delay(input int j);
    if (j == 0) return '0;
    return TW'((NFFT >> j) + BF_LAT - 1);
  endfunction

  always_comb begin
    n_in_act = in_act;
    n_in_cnt = in_cnt;
    accept   = 1'b0;
    flush    = 1'b0;
    sof_err  = 1'b0;
    if (in_act) begin
      if (!in_valid) begin
        flush = 1'b1;
      end else begin
        sof_err  = in_sof;
        n_in_cnt = in_cnt + 1'b1;
        if (in_cnt == {L{1'b1}}) n_in_act = 1'b0;
      end
    end else if (in_valid && in_sof) begin
      accept   = 1'b1;
      n_in_act = 1'b1;
      n_in_cnt = L'(1);
    end
    if (flush) begin
      n_in_act = 1'b0;
      n_in_cnt = '0;
    end

    for (int j = 0; j <= L; j++) expire[j] = tok_vld[j] && (tok_cnt[j] == '0);
    load = {expire[L-1:0], accept};

    for (int j = 0; j <= L; j++) begin
      n_tok_vld[j] = tok_vld[j];
      n_tok_cnt[j] = tok_cnt[j];
      if (load[j]) begin
        n_tok_vld[j] = 1'b1;
        n_tok_cnt[j] = tok_delay(j);
      end else if (expire[j]) begin
        n_tok_vld[j] = 1'b0;
      end else if (tok_vld[j]) begin
        n_tok_cnt[j] = tok_cnt[j] - 1'b1;
      end

      // A landing token restarts k at 0, giving a seamless wrap back-to-back.
      n_st_act[j] = st_act[j];
      n_st_k[j]   = st_k[j];
      if (expire[j]) begin
        n_st_act[j] = 1'b1;
        n_st_k[j]   = '0;
      end else if (st_act[j]) begin
        if (st_k[j] == {L{1'b1}}) n_st_act[j] = 1'b0;
        else                      n_st_k[j]   = st_k[j] + 1'b1;
      end

      if (flush) begin
        n_tok_vld[j] = 1'b0;
        n_st_act[j]  = 1'b0;
      end
    end

    for (int s = 1; s <= L; s++) begin
      n_bf_sel[s-1]    = n_st_act[s-1] & n_st_k[s-1][L-s];
      n_tw_active[s-1] = n_tok_vld[s-1] && (n_tok_cnt[s-1] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_act       <= 1'b0;
      in_cnt       <= '0;
      tok_vld      <= '0;
      st_act       <= '0;
      tok_cnt      <= '{default: '0};
      st_k         <= '{default: '0};
      bf_sel       <= '0;
      tw_active    <= '0;
      out_valid    <= 1'b0;
      out_sof      <= 1'b0;
      busy         <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      in_act       <= n_in_act;
      in_cnt       <= n_in_cnt;
      tok_vld      <= n_tok_vld;
      st_act       <= n_st_act;
      tok_cnt      <= n_tok_cnt;
      st_k         <= n_st_k;
      bf_sel       <= n_bf_sel;
      tw_active    <= n_tw_active;
      out_valid    <= n_st_act[L];
      out_sof      <= n_st_act[L] && (n_st_k[L] == '0);
      busy         <= n_in_act | (|n_tok_vld) | (|n_st_act);
      err_protocol <= err_protocol | flush | sof_err;
    end
  end

endmodule
